// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_arbiter_pkg : shared bus widths, arbiter state codes, timeout     |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
package mem_bus_arbiter_pkg;

  localparam int ADDR_BUS        = 32;
  localparam int DATA_BUS        = 32;
  localparam int MEM_SEL_BUS     = 4;
  localparam int DEFAULT_TIMEOUT = 255;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t ST_IDLE    = 2'd0;
  localparam arb_state_t ST_REQ_RAM = 2'd1;
  localparam arb_state_t ST_REQ_ROM = 2'd2;
  localparam arb_state_t ST_RELEASE = 2'd3;

  function automatic logic is_req_state(input arb_state_t s);
    return (s == ST_REQ_RAM) || (s == ST_REQ_ROM);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_arbiter_watchdog : wait counter, one-cycle expire strobe          |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_bus_arbiter_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  generate
    if (TIMEOUT > 0) begin : g_enabled
      localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
      localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

      logic [CNT_W-1:0] count_q;

      // Fires on the TIMEOUT-th consecutive waiting cycle.
      assign expire_o = en_i && (count_q == LAST);

      always_ff @(posedge clk) begin
        if (!rst) begin
          count_q <= '0;
        end else if (clr_i || expire_o) begin
          count_q <= '0;
        end else if (en_i) begin
          count_q <= count_q + 1'b1;
        end
      end
    end else begin : g_disabled
      logic unused_inputs;
      assign unused_inputs = ^{clk, rst, clr_i, en_i};
      assign expire_o      = 1'b0;
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mem_bus_arbiter : serialises core RAM/ROM ports onto one memory bus       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_BUS,
  parameter int DATA_W  = DATA_BUS,
  parameter int SEL_W   = MEM_SEL_BUS,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rom_en,
  input  logic [SEL_W-1:0]  rom_write_en,
  input  logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_write_data,
  output logic [DATA_W-1:0] rom_read_data,
  input  logic              ram_en,
  input  logic [SEL_W-1:0]  ram_write_en,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] ram_write_data,
  output logic [DATA_W-1:0] ram_read_data,
  output logic              stall,
  output logic              bus_req,
  output logic [SEL_W-1:0]  bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  arb_state_t        state_d,     state_q;
  logic              pend_rom_d,  pend_rom_q;
  logic [SEL_W-1:0]  pend_we_d,   pend_we_q;
  logic [ADDR_W-1:0] pend_addr_d, pend_addr_q;
  logic [DATA_W-1:0] pend_wd_d,   pend_wd_q;
  logic              bus_req_d,   bus_req_q;
  logic [SEL_W-1:0]  bus_we_d,    bus_we_q;
  logic [ADDR_W-1:0] bus_addr_d,  bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_d, bus_wdata_q;
  logic [DATA_W-1:0] rom_rd_d,    rom_rd_q;
  logic [DATA_W-1:0] ram_rd_d,    ram_rd_q;
  logic              bus_err_d,   bus_err_q;

  logic              wd_clr;
  logic              wd_en;
  logic              wd_expire;
  logic              phase_done;
  logic [DATA_W-1:0] phase_data;

  assign wd_en      = is_req_state(state_q) && !bus_ack;
  assign phase_done = bus_ack || wd_expire;
  // An abandoned transaction returns zero; ack always takes priority.
  assign phase_data = bus_ack ? bus_rdata : '0;

  mem_bus_arbiter_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );

  always_comb begin
    state_d     = state_q;
    pend_rom_d  = pend_rom_q;
    pend_we_d   = pend_we_q;
    pend_addr_d = pend_addr_q;
    pend_wd_d   = pend_wd_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rom_rd_d    = rom_rd_q;
    ram_rd_d    = ram_rd_q;
    bus_err_d   = bus_err_q;
    wd_clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (rom_en || ram_en) begin
          // The ROM request is captured now so a later phase is immune to port changes.
          pend_rom_d  = rom_en;
          pend_we_d   = rom_write_en;
          pend_addr_d = rom_addr;
          pend_wd_d   = rom_write_data;
          bus_req_d   = 1'b1;
          wd_clr      = 1'b1;
          if (ram_en) begin
            bus_we_d    = ram_write_en;
            bus_addr_d  = ram_addr;
            bus_wdata_d = ram_write_data;
            state_d     = ST_REQ_RAM;
          end else begin
            bus_we_d    = rom_write_en;
            bus_addr_d  = rom_addr;
            bus_wdata_d = rom_write_data;
            state_d     = ST_REQ_ROM;
          end
        end
      end

      ST_REQ_RAM: begin
        if (phase_done) begin
          ram_rd_d = phase_data;
          if (!bus_ack) begin
            bus_err_d = 1'b1;
          end
          if (pend_rom_q) begin
            pend_rom_d  = 1'b0;
            bus_we_d    = pend_we_q;
            bus_addr_d  = pend_addr_q;
            bus_wdata_d = pend_wd_q;
            wd_clr      = 1'b1;
            state_d     = ST_REQ_ROM;
          end else begin
            bus_req_d = 1'b0;
            state_d   = ST_RELEASE;
          end
        end
      end

      ST_REQ_ROM: begin
        if (phase_done) begin
          rom_rd_d   = phase_data;
          pend_rom_d = 1'b0;
          if (!bus_ack) begin
            bus_err_d = 1'b1;
          end
          bus_req_d = 1'b0;
          state_d   = ST_RELEASE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      pend_rom_q  <= 1'b0;
      pend_we_q   <= '0;
      pend_addr_q <= '0;
      pend_wd_q   <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      rom_rd_q    <= '0;
      ram_rd_q    <= '0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_rom_q  <= pend_rom_d;
      pend_we_q   <= pend_we_d;
      pend_addr_q <= pend_addr_d;
      pend_wd_q   <= pend_wd_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rom_rd_q    <= rom_rd_d;
      ram_rd_q    <= ram_rd_d;
      bus_err_q   <= bus_err_d;
    end
  end

  assign stall = ((state_q == ST_IDLE) && (rom_en || ram_en)) || is_req_state(state_q);

  assign bus_req       = bus_req_q;
  assign bus_we        = bus_we_q;
  assign bus_addr      = bus_addr_q;
  assign bus_wdata     = bus_wdata_q;
  assign rom_read_data = rom_rd_q;
  assign ram_read_data = ram_rd_q;
  assign bus_err       = bus_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mem_bus_arbiter : directed + randomized access bench                   |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_mem_bus_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rom_en = 1'b0;
  logic [3:0]  rom_write_en = '0;
  logic [31:0] rom_addr = '0;
  logic [31:0] rom_write_data = '0;
  logic [31:0] rom_read_data;
  logic        ram_en = 1'b0;
  logic [3:0]  ram_write_en = '0;
  logic [31:0] ram_addr = '0;
  logic [31:0] ram_write_data = '0;
  logic [31:0] ram_read_data;
  logic        stall;
  logic        bus_req;
  logic [3:0]  bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata = '0;
  logic        bus_ack = 1'b0;
  logic        bus_err;

  int          n_checks = 0;
  int          n_fails  = 0;

  logic [31:0] exp_rom_buf = '0;
  logic [31:0] exp_ram_buf = '0;
  logic        exp_err     = 1'b0;

  mem_bus_arbiter #(
    .ADDR_W  (32),
    .DATA_W  (32),
    .SEL_W   (4),
    .TIMEOUT (TMO)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_en         (rom_en),
    .rom_write_en   (rom_write_en),
    .rom_addr       (rom_addr),
    .rom_write_data (rom_write_data),
    .rom_read_data  (rom_read_data),
    .ram_en         (ram_en),
    .ram_write_en   (ram_write_en),
    .ram_addr       (ram_addr),
    .ram_write_data (ram_write_data),
    .ram_read_data  (ram_read_data),
    .stall          (stall),
    .bus_req        (bus_req),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_ack        (bus_ack),
    .bus_err        (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Port inputs are frozen-core garbage once the request is accepted.
  task automatic scramble_ports();
    rom_en         = 1'($urandom);
    ram_en         = 1'($urandom);
    rom_write_en   = 4'($urandom);
    ram_write_en   = 4'($urandom);
    rom_addr       = $urandom;
    ram_addr       = $urandom;
    rom_write_data = $urandom;
    ram_write_data = $urandom;
  endtask

  // One bus phase: slave acks on wait cycle 'lat' (0-based), or never if lat >= TMO.
  task automatic run_phase(input logic [3:0] we, input logic [31:0] addr,
                           input logic [31:0] wd, input int lat,
                           input logic [31:0] rdata, output logic [31:0] served);
    int ncyc;
    ncyc = (lat < TMO) ? lat + 1 : TMO;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      bus_ack = 1'b0;
      scramble_ports();
      #1;
      check_eq("req_bus_req", bus_req, 1'b1);
      check_eq("req_stall", stall, 1'b1);
      check_eq("req_addr", bus_addr, addr);
      check_eq("req_we", bus_we, we);
      check_eq("req_wdata", bus_wdata, wd);
      if (c == lat) begin
        bus_ack   = 1'b1;
        bus_rdata = rdata;
      end else begin
        bus_rdata = $urandom;
      end
    end
    if (lat < TMO) begin
      served = rdata;
    end else begin
      served  = '0;
      exp_err = 1'b1;
    end
  endtask

  task automatic do_access(input logic ren, input logic [3:0] rwe, input logic [31:0] raddr,
                           input logic [31:0] rwd, input logic fen, input logic [3:0] fwe,
                           input logic [31:0] faddr, input logic [31:0] fwd,
                           input int lat_ram, input int lat_rom,
                           input logic [31:0] d_ram, input logic [31:0] d_rom);
    logic [31:0] v;
    @(negedge clk);
    bus_ack        = 1'b0;
    ram_en         = ren;
    ram_write_en   = rwe;
    ram_addr       = raddr;
    ram_write_data = rwd;
    rom_en         = fen;
    rom_write_en   = fwe;
    rom_addr       = faddr;
    rom_write_data = fwd;
    #1;
    check_eq("idle_stall", stall, ren | fen);
    check_eq("idle_bus_req", bus_req, 1'b0);
    if (ren) begin
      run_phase(rwe, raddr, rwd, lat_ram, d_ram, v);
      exp_ram_buf = v;
    end
    if (fen) begin
      run_phase(fwe, faddr, fwd, lat_rom, d_rom, v);
      exp_rom_buf = v;
    end
    if (ren || fen) begin
      @(negedge clk);
      rom_en    = 1'b0;
      ram_en    = 1'b0;
      bus_ack   = 1'($urandom);
      bus_rdata = $urandom;
      #1;
      check_eq("rel_stall", stall, 1'b0);
      check_eq("rel_bus_req", bus_req, 1'b0);
      check_eq("rel_ram_buf", ram_read_data, exp_ram_buf);
      check_eq("rel_rom_buf", rom_read_data, exp_rom_buf);
      check_eq("rel_bus_err", bus_err, exp_err);
    end else begin
      rom_en = 1'b0;
      ram_en = 1'b0;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_stall"}, stall, 1'b0);
    check_eq({tag, "_bus_req"}, bus_req, 1'b0);
    check_eq({tag, "_bus_we"}, bus_we, '0);
    check_eq({tag, "_bus_addr"}, bus_addr, '0);
    check_eq({tag, "_bus_wdata"}, bus_wdata, '0);
    check_eq({tag, "_rom_buf"}, rom_read_data, '0);
    check_eq({tag, "_ram_buf"}, ram_read_data, '0);
    check_eq({tag, "_bus_err"}, bus_err, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_state("reset");

    // Instruction fetch, two-cycle wait phase.
    do_access(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'hBFC0_0000, 32'h0,
              0, 1, 32'h0, 32'h2401_0001);
    // Load plus fetch, immediate acks, back-to-back.
    do_access(1'b1, 4'h0, 32'h8000_0010, 32'h0, 1'b1, 4'h0, 32'hBFC0_0004, 32'h0,
              0, 0, 32'hCAFE_0010, 32'h8C22_0000);
    // Store with byte enables, held for three cycles.
    do_access(1'b1, 4'b0011, 32'h8000_0020, 32'h1234_5678, 1'b0, 4'h0, 32'h0, 32'h0,
              2, 0, 32'h5555_AAAA, 32'h0);
    // Ack lands on the very cycle the watchdog would expire.
    do_access(1'b1, 4'h0, 32'h8000_0030, 32'h0, 1'b1, 4'h0, 32'hBFC0_0008, 32'h0,
              TMO - 1, TMO - 1, 32'hDEAD_BEEF, 32'h0BAD_F00D);
    // Abandoned fetch, then a normal access with the sticky error.
    do_access(1'b0, 4'h0, 32'h0, 32'h0, 1'b1, 4'h0, 32'hBFC0_000C, 32'h0,
              0, TMO + 1, 32'h0, 32'h1111_2222);
    do_access(1'b1, 4'h0, 32'h8000_0040, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0,
              1, 0, 32'h7777_8888, 32'h0);

    // Reset while a ROM phase is outstanding, then a stray ack in IDLE.
    @(negedge clk);
    rom_en   = 1'b1;
    rom_addr = 32'hBFC0_0010;
    @(negedge clk);
    rom_en = 1'b0;
    #1;
    check_eq("mid_bus_req", bus_req, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_rom_buf = '0;
    exp_ram_buf = '0;
    exp_err     = 1'b0;
    check_reset_state("midrst");
    bus_ack   = 1'b1;
    bus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check_reset_state("stray_ack");

    for (int i = 0; i < 60; i++) begin
      do_access(1'($urandom), 4'($urandom), $urandom, $urandom,
                1'($urandom), 4'($urandom), $urandom, $urandom,
                int'($urandom_range(0, TMO + 1)), int'($urandom_range(0, TMO + 1)),
                $urandom, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
